alu_imm_pipeline: RTL and testbench
===================================

ALU_IMM_PIPELINE -- requirements
Module: alu_imm_pipeline

Interface
REQ-001 SHALL take parameters from core_types_pkg (name, default, meaning): PRF_BANK_COUNT, 4, PRF banks; LOG_PRF_BANK_COUNT, 2, bank select width; LOG_PR_COUNT, 7, physical register tag width; LOG_ROB_ENTRIES, 7, ROB index width.
REQ-002 SHALL have one clock and a synchronous, active-high reset: CLK  in  1  clock; RST  in  1  reset, sampled on CLK rising edge.
REQ-003 SHALL have issue inputs: issue_valid in 1; issue_op in 4 (ALU op); issue_imm12 in 12; issue_A_forward in 1; issue_A_is_zero in 1; issue_A_bank in LOG_PRF_BANK_COUNT; issue_dest_PR in LOG_PR_COUNT; issue_ROB_index in LOG_ROB_ENTRIES.
REQ-004 SHALL have issue_ready  out  1  this block accepts an issue this cycle.
REQ-005 SHALL have reg_read_ack_by_bank  in  PRF_BANK_COUNT  PRF read data valid per bank; reg_read_data_by_bank  in  PRF_BANK_COUNT x 32  PRF read data.
REQ-006 SHALL have forward_data_by_bank  in  PRF_BANK_COUNT x 32  writeback bus data per bank.
REQ-007 SHALL have WB outputs: WB_valid out 1; WB_data out 32; WB_PR out LOG_PR_COUNT; WB_ROB_index out LOG_ROB_ENTRIES; and WB_ready  in  1  consumer accepts WB.

Function
REQ-008 SHALL contain two stages: OC (operand collect + execute) and WB (registered output); each holds one op with a valid bit.
REQ-009 SHALL load OC on the CLK edge where issue_valid & issue_ready; issue_ready SHALL be ~OC_valid | OC_advance (combinational).
REQ-010 SHALL resolve operand A in OC by priority: A_is_zero -> 0; else A_forward -> forward_data_by_bank[A_bank] sampled only in the first OC cycle; else first cycle reg_read_ack_by_bank[A_bank]=1 -> reg_read_data_by_bank[A_bank].
REQ-011 SHALL latch a collected A into an OC operand register with a collected flag when OC cannot advance, and use the latched value on later cycles; later acks/forward data SHALL be ignored once collected.
REQ-012 SHALL define OC_ready_to_exec = OC_valid & (collected | current-cycle source available per REQ-010) and OC_advance = OC_ready_to_exec & (~WB_valid | WB_ready).
REQ-013 SHALL compute in OC, with I = sign-extended imm12 and sh = imm12[4:0]: op 0000 ADD A+I (mod 2^32); x001 SLL A<<sh; x010 SLT signed A<I ? 1:0; x011 SLTU unsigned A<I ? 1:0; x100 XOR; 0101 SRL logical; 1101 SRA arithmetic; x110 OR; x111 AND; op 1000 SHALL behave as ADD (op[3] significant only for 101).
REQ-014 SHALL load WB with result, dest_PR, ROB_index and set WB_valid on OC_advance; clear WB_valid when WB_valid & WB_ready & ~OC_advance.
REQ-015 SHALL hold WB outputs stable while WB_valid & ~WB_ready.
REQ-016 SHALL allow simultaneous WB drain, OC->WB move and new issue into OC in one cycle (full throughput 1 op/cycle, issue-to-WB_valid latency 2 cycles with operand present in first OC cycle).
REQ-017 SHALL stall OC indefinitely if a non-forward, non-zero operand never receives an ack; issue_ready stays 0 meanwhile.
REQ-018 SHALL treat a forward op whose OC first cycle stalls on WB as collected via REQ-011, producing the correct result after the stall.
REQ-019 SHALL have no combinational path from reg_read/forward data to issue_ready other than through ack bits.

Reset
REQ-020 SHALL, while RST=1 at a CLK edge, clear OC_valid, collected, WB_valid, and all WB data/PR/ROB_index registers to 0; issue_ready SHALL read 1 after reset.
REQ-021 SHALL discard any op in flight when RST is asserted mid-operation; no WB_valid for it after reset release.

Verification
REQ-022 SHALL pass: issue ADD imm12=0xFFF, A_is_zero=1, dest_PR=5, ROB=9, WB_ready=1 -> 2 cycles later WB_valid=1, WB_data=0xFFFFFFFF, WB_PR=5, WB_ROB_index=9.
REQ-023 SHALL pass: SRA sh=4 via A_forward bank 2, forward_data_by_bank[2]=0x80000000 in first OC cycle, WB_ready=0 for 3 cycles -> WB_data=0xF8000000 held stable until WB_ready=1, issue_ready=0 while OC full and WB blocked.
REQ-024 SHALL pass: SLTU imm12=0x001, A from PRF bank 1, ack after 3 OC cycles with data 0 -> WB_data=1; SLT same with data 0xFFFFFFFF, imm 0 -> WB_data=1.
REQ-025 SHALL pass: back-to-back 4 ADDI ops with zero operands, WB_ready=1 -> 4 consecutive WB_valid cycles in order, issue_ready constantly 1.
REQ-026 SHALL pass: RST=1 for one cycle with OC and WB full -> next cycle WB_valid=0, WB_data=0, issue_ready=1.
REQ-027 SHALL pass: ack on bank 0 while op waits on bank 3 -> no collection, OC stalls; later ack on bank 3 data 0x10 with ORI 0x00F -> WB_data=0x1F.

Source files
------------

// File: rtl/alu_imm_pipeline_if.sv
// ----------------------------------------------------------------------------
// core_types_pkg : shared core sizing parameters.
// alu_imm_pipeline_if : issue / PRF read / forward / writeback bundle of the
//    immediate-ALU pipeline.
//    slave  modport : the pipeline side (consumes issue, produces WB).
//    master modport : the surrounding core (issue queue, PRF, WB consumer).
//    Signals: issue_* (op, imm12, operand-A source, dest PR, ROB index),
//    issue_ready, reg_read_ack/data_by_bank, forward_data_by_bank,
//    wb_valid/data/pr/rob_index, wb_ready.
// ----------------------------------------------------------------------------
package core_types_pkg;
   localparam int PRF_BANK_COUNT     = 4;
   localparam int LOG_PRF_BANK_COUNT = 2;
   localparam int LOG_PR_COUNT       = 7;
   localparam int LOG_ROB_ENTRIES    = 7;
endpackage

interface alu_imm_pipeline_if;
   import core_types_pkg::*;

   logic                                 issue_valid;
   logic [3:0]                           issue_op;
   logic [11:0]                          issue_imm12;
   logic                                 issue_a_forward;
   logic                                 issue_a_is_zero;
   logic [LOG_PRF_BANK_COUNT-1:0]        issue_a_bank;
   logic [LOG_PR_COUNT-1:0]              issue_dest_pr;
   logic [LOG_ROB_ENTRIES-1:0]           issue_rob_index;
   logic                                 issue_ready;

   logic [PRF_BANK_COUNT-1:0]            reg_read_ack_by_bank;
   logic [PRF_BANK_COUNT-1:0][31:0]      reg_read_data_by_bank;
   logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank;

   logic                                 wb_valid;
   logic [31:0]                          wb_data;
   logic [LOG_PR_COUNT-1:0]              wb_pr;
   logic [LOG_ROB_ENTRIES-1:0]           wb_rob_index;
   logic                                 wb_ready;

   modport slave (
      input  issue_valid, issue_op, issue_imm12, issue_a_forward, issue_a_is_zero,
      input  issue_a_bank, issue_dest_pr, issue_rob_index,
      output issue_ready,
      input  reg_read_ack_by_bank, reg_read_data_by_bank, forward_data_by_bank,
      output wb_valid, wb_data, wb_pr, wb_rob_index,
      input  wb_ready
   );

   modport master (
      output issue_valid, issue_op, issue_imm12, issue_a_forward, issue_a_is_zero,
      output issue_a_bank, issue_dest_pr, issue_rob_index,
      input  issue_ready,
      output reg_read_ack_by_bank, reg_read_data_by_bank, forward_data_by_bank,
      input  wb_valid, wb_data, wb_pr, wb_rob_index,
      output wb_ready
   );
endinterface

// File: rtl/alu_imm_pipeline.sv
// ----------------------------------------------------------------------------
// alu_imm_pipeline : two-stage register-immediate ALU.
//    OC stage collects operand A (zero / forward bus / PRF read) and executes;
//    WB stage holds the registered result until the consumer accepts it.
// Ports:
//    i_clk  : clock
//    i_rst  : synchronous active-high reset
//    if_alu : alu_imm_pipeline_if.slave (issue, PRF read, forward, WB)
// ----------------------------------------------------------------------------
module alu_imm_pipeline
   import core_types_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   alu_imm_pipeline_if.slave    if_alu
);

   // ALU operation; op[3] only selects arithmetic vs logical right shift.
   function automatic logic [31:0] alu_f(input logic [3:0]  op,
                                         input logic [31:0] a,
                                         input logic [11:0] imm);
      logic [31:0] imm_s;
      logic [4:0]  sh;
      logic [31:0] res;
      imm_s = {{20{imm[11]}}, imm};
      sh    = imm[4:0];
      case (op[2:0])
         3'b000:  res = a + imm_s;
         3'b001:  res = a << sh;
         3'b010:  res = ($signed(a) < $signed(imm_s)) ? 32'h0000_0001 : 32'h0000_0000;
         3'b011:  res = (a < imm_s) ? 32'h0000_0001 : 32'h0000_0000;
         3'b100:  res = a ^ imm_s;
         3'b101:  res = op[3] ? 32'($signed(a) >>> sh) : (a >> sh);
         3'b110:  res = a | imm_s;
         3'b111:  res = a & imm_s;
         default: res = a + imm_s;
      endcase
      return res;
   endfunction

   logic                            r_oc_valid;
   logic                            r_oc_first;
   logic                            r_oc_collected;
   logic [3:0]                      r_oc_op;
   logic [11:0]                     r_oc_imm;
   logic                            r_oc_a_forward;
   logic                            r_oc_a_is_zero;
   logic [LOG_PRF_BANK_COUNT-1:0]   r_oc_a_bank;
   logic [LOG_PR_COUNT-1:0]         r_oc_dest_pr;
   logic [LOG_ROB_ENTRIES-1:0]      r_oc_rob_index;
   logic [31:0]                     r_oc_a;

   logic                            r_wb_valid;
   logic [31:0]                     r_wb_data;
   logic [LOG_PR_COUNT-1:0]         r_wb_pr;
   logic [LOG_ROB_ENTRIES-1:0]      r_wb_rob_index;

   logic                            w_src_avail;
   logic [31:0]                     w_a_now;
   logic [31:0]                     w_a;
   logic                            w_ready_exec;
   logic                            w_oc_advance;
   logic                            w_issue_fire;
   logic [31:0]                     w_result;

   // Current-cycle operand source: zero wins, forward bus only in the first
   // OC cycle, otherwise whichever cycle the selected PRF bank acks.
   always_comb begin
      w_src_avail = 1'b0;
      w_a_now     = 32'h0000_0000;
      if (r_oc_a_is_zero) begin
         w_src_avail = 1'b1;
         w_a_now     = 32'h0000_0000;
      end else if (r_oc_a_forward) begin
         w_src_avail = r_oc_first;
         w_a_now     = if_alu.forward_data_by_bank[r_oc_a_bank];
      end else begin
         w_src_avail = if_alu.reg_read_ack_by_bank[r_oc_a_bank];
         w_a_now     = if_alu.reg_read_data_by_bank[r_oc_a_bank];
      end
   end

   // Once collected, the latched operand wins over anything on the buses.
   always_comb begin
      w_a = 32'h0000_0000;
      if (r_oc_collected) begin
         w_a = r_oc_a;
      end else begin
         w_a = w_a_now;
      end
   end

   // Handshake: issue_ready depends only on state, ack bits and WB_ready,
   // never on read/forward data.
   always_comb begin
      w_ready_exec = r_oc_valid & (r_oc_collected | w_src_avail);
      w_oc_advance = w_ready_exec & (~r_wb_valid | if_alu.wb_ready);
      w_issue_fire = if_alu.issue_valid & (~r_oc_valid | w_oc_advance);
      w_result     = alu_f(r_oc_op, w_a, r_oc_imm);
   end

   // OC stage: load on issue, empty on advance, else capture A when it appears.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_oc_valid     <= 1'b0;
         r_oc_first     <= 1'b0;
         r_oc_collected <= 1'b0;
         r_oc_op        <= 4'h0;
         r_oc_imm       <= 12'h000;
         r_oc_a_forward <= 1'b0;
         r_oc_a_is_zero <= 1'b0;
         r_oc_a_bank    <= '0;
         r_oc_dest_pr   <= '0;
         r_oc_rob_index <= '0;
         r_oc_a         <= 32'h0000_0000;
      end else if (w_issue_fire) begin
         r_oc_valid     <= 1'b1;
         r_oc_first     <= 1'b1;
         r_oc_collected <= 1'b0;
         r_oc_op        <= if_alu.issue_op;
         r_oc_imm       <= if_alu.issue_imm12;
         r_oc_a_forward <= if_alu.issue_a_forward;
         r_oc_a_is_zero <= if_alu.issue_a_is_zero;
         r_oc_a_bank    <= if_alu.issue_a_bank;
         r_oc_dest_pr   <= if_alu.issue_dest_pr;
         r_oc_rob_index <= if_alu.issue_rob_index;
         r_oc_a         <= 32'h0000_0000;
      end else if (w_oc_advance) begin
         r_oc_valid     <= 1'b0;
         r_oc_first     <= 1'b0;
         r_oc_collected <= 1'b0;
      end else if (r_oc_valid) begin
         r_oc_first <= 1'b0;
         // Stalled on WB: keep the operand, since the forward bus is gone next cycle.
         if (!r_oc_collected && w_src_avail) begin
            r_oc_collected <= 1'b1;
            r_oc_a         <= w_a_now;
         end
      end
   end

   // WB stage: take OC result on advance, drop valid once consumed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wb_valid     <= 1'b0;
         r_wb_data      <= 32'h0000_0000;
         r_wb_pr        <= '0;
         r_wb_rob_index <= '0;
      end else if (w_oc_advance) begin
         r_wb_valid     <= 1'b1;
         r_wb_data      <= w_result;
         r_wb_pr        <= r_oc_dest_pr;
         r_wb_rob_index <= r_oc_rob_index;
      end else if (r_wb_valid && if_alu.wb_ready) begin
         r_wb_valid     <= 1'b0;
      end
   end

   assign if_alu.issue_ready  = ~r_oc_valid | w_oc_advance;
   assign if_alu.wb_valid     = r_wb_valid;
   assign if_alu.wb_data      = r_wb_data;
   assign if_alu.wb_pr        = r_wb_pr;
   assign if_alu.wb_rob_index = r_wb_rob_index;

endmodule

// File: tb/tb_alu_imm_pipeline.sv
// ----------------------------------------------------------------------------
// tb_alu_imm_pipeline : directed scenarios plus randomized traffic for
//    alu_imm_pipeline. Expected WB beats are queued at issue time and a
//    separate monitor pops them whenever the DUT hands off a WB beat.
// ----------------------------------------------------------------------------
module tb_alu_imm_pipeline;
   import core_types_pkg::*;

   typedef struct packed {
      logic [31:0]                data;
      logic [LOG_PR_COUNT-1:0]    pr;
      logic [LOG_ROB_ENTRIES-1:0] rob;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_imm_pipeline_if bus ();
   alu_imm_pipeline dut (.i_clk(clk), .i_rst(rst), .if_alu(bus));

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Random-phase view of the op sitting in OC and the op being offered.
   bit                            occ = 1'b0;
   int                            oc_mode, oc_wait, oc_delay;
   bit                            oc_first;
   logic [LOG_PRF_BANK_COUNT-1:0] oc_bank;
   logic [31:0]                   oc_aval;
   int                            p_mode, p_delay;
   logic [3:0]                    p_op;
   logic [11:0]                   p_imm;
   logic [LOG_PRF_BANK_COUNT-1:0] p_bank;
   logic [LOG_PR_COUNT-1:0]       p_pr;
   logic [LOG_ROB_ENTRIES-1:0]    p_rob;
   logic [31:0]                   p_aval;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Reference semantics in plain arithmetic (shifts as multiply/divide).
   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [11:0] imm);
      logic [31:0] i;
      logic [31:0] pow;
      i   = imm[11] ? {20'hFFFFF, imm} : {20'h00000, imm};
      pow = 32'd1 << imm[4:0];
      case (op[2:0])
         3'b000:  return a + i;
         3'b001:  return a * pow;
         3'b010:  return ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
         3'b011:  return (a < i) ? 32'd1 : 32'd0;
         3'b100:  return a ^ i;
         3'b110:  return a | i;
         3'b111:  return a & i;
         default: return (op[3] && a[31]) ? ~((~a) / pow) : (a / pow);
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.issue_valid           = 1'b0;
      bus.issue_op              = 4'h0;
      bus.issue_imm12           = 12'h000;
      bus.issue_a_forward       = 1'b0;
      bus.issue_a_is_zero       = 1'b0;
      bus.issue_a_bank          = '0;
      bus.issue_dest_pr         = '0;
      bus.issue_rob_index       = '0;
      bus.reg_read_ack_by_bank  = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         bus.reg_read_data_by_bank[b] = 32'hA5A5_A5A5;
         bus.forward_data_by_bank[b]  = 32'hDEAD_BEEF;
      end
      bus.wb_ready              = 1'b1;
   endtask

   task automatic set_issue(input logic [3:0] op, input logic [11:0] imm, input logic fwd,
                            input logic zero, input logic [LOG_PRF_BANK_COUNT-1:0] bank,
                            input logic [LOG_PR_COUNT-1:0] pr,
                            input logic [LOG_ROB_ENTRIES-1:0] rob);
      bus.issue_valid     = 1'b1;
      bus.issue_op        = op;
      bus.issue_imm12     = imm;
      bus.issue_a_forward = fwd;
      bus.issue_a_is_zero = zero;
      bus.issue_a_bank    = bank;
      bus.issue_dest_pr   = pr;
      bus.issue_rob_index = rob;
   endtask

   task automatic expect_wb(input logic [3:0] op, input logic [31:0] a, input logic [11:0] imm,
                            input logic [LOG_PR_COUNT-1:0] pr,
                            input logic [LOG_ROB_ENTRIES-1:0] rob);
      exp_q.push_back({ref_result(op, a, imm), pr, rob});
   endtask

   // One randomized cycle: drive buses for the op in OC, maybe offer a new op.
   task automatic rand_cycle(input bit allow_issue);
      logic [PRF_BANK_COUNT-1:0] acks;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         bus.forward_data_by_bank[b]  = $urandom;
         bus.reg_read_data_by_bank[b] = $urandom;
         acks[b]                      = 1'($urandom_range(0, 1));
      end
      if (occ && oc_mode == 2) begin
         acks[oc_bank] = 1'b0;
         if (oc_wait == oc_delay) begin
            acks[oc_bank] = 1'b1;
            bus.reg_read_data_by_bank[oc_bank] = oc_aval;
         end else if (oc_wait > oc_delay) begin
            acks[oc_bank] = 1'b1;   // stale re-ack with junk data
         end
      end
      if (occ && oc_mode == 1 && oc_first) bus.forward_data_by_bank[oc_bank] = oc_aval;
      bus.reg_read_ack_by_bank = acks;
      bus.wb_ready = allow_issue ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (allow_issue && $urandom_range(0, 3) != 0) begin
         p_mode  = int'($urandom_range(0, 2));
         p_op    = 4'($urandom);
         p_imm   = 12'($urandom);
         p_bank  = LOG_PRF_BANK_COUNT'($urandom);
         p_pr    = LOG_PR_COUNT'($urandom);
         p_rob   = LOG_ROB_ENTRIES'($urandom);
         p_delay = int'($urandom_range(0, 4));
         case ($urandom_range(0, 3))
            0:       p_aval = 32'h8000_0000;
            1:       p_aval = 32'hFFFF_FFFF;
            default: p_aval = $urandom;
         endcase
         if (p_mode == 0) p_aval = 32'h0000_0000;
         set_issue(p_op, p_imm, (p_mode == 1) || (p_mode == 0 && $urandom_range(0, 1) == 1),
                   p_mode == 0, p_bank, p_pr, p_rob);
      end else begin
         bus.issue_valid = 1'b0;
      end
      @(negedge clk);
      if (occ && bus.issue_ready) begin
         occ = 1'b0;
      end else if (occ) begin
         oc_first = 1'b0;
         oc_wait++;
      end
      if (bus.issue_valid && bus.issue_ready) begin
         occ = 1'b1; oc_mode = p_mode; oc_bank = p_bank; oc_aval = p_aval;
         oc_delay = p_delay; oc_first = 1'b1; oc_wait = 0;
         expect_wb(p_op, p_aval, p_imm, p_pr, p_rob);
      end
      cyc();
   endtask

   // Monitor: score every WB hand-off and check stability while stalled.
   initial begin : monitor
      exp_t e;
      exp_t held;
      bit   held_v;
      held_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               check("wb_hold_valid", 32'(bus.wb_valid), 32'd1);
               check("wb_hold_data", bus.wb_data, held.data);
               check("wb_hold_pr", 32'(bus.wb_pr), 32'(held.pr));
               check("wb_hold_rob", 32'(bus.wb_rob_index), 32'(held.rob));
            end
            held_v = 1'b0;
            if (bus.wb_valid && bus.wb_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL wb_unexpected: got beat data 0x%08h, required no beat", bus.wb_data);
               end else begin
                  e = exp_q.pop_front();
                  check("wb_data", bus.wb_data, e.data);
                  check("wb_pr", 32'(bus.wb_pr), 32'(e.pr));
                  check("wb_rob", 32'(bus.wb_rob_index), 32'(e.rob));
               end
            end else if (bus.wb_valid) begin
               held_v = 1'b1;
               held   = {bus.wb_data, bus.wb_pr, bus.wb_rob_index};
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: run still active at time limit, required completion");
      $fatal(1);
   end

   initial begin : main
      logic [7:0] vbits;
      idle_inputs();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      @(negedge clk);
      check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("reset_wb_data", bus.wb_data, 32'd0);
      check("reset_wb_pr_rob", 32'({bus.wb_pr, bus.wb_rob_index}), 32'd0);
      check("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
      cyc();

      // ADD imm 0xFFF with zero operand: WB two edges after issue.
      set_issue(4'b0000, 12'hFFF, 1'b0, 1'b1, 2'd0, 7'd5, 7'd9);
      expect_wb(4'b0000, 32'h0, 12'hFFF, 7'd5, 7'd9);
      cyc();
      idle_inputs();
      @(negedge clk);
      check("add_lat_early", 32'(bus.wb_valid), 32'd0);
      cyc();
      @(negedge clk);
      check("add_lat_valid", 32'(bus.wb_valid), 32'd1);
      check("add_data", bus.wb_data, 32'hFFFF_FFFF);
      cyc();

      // SRA via forward bank 2 with WB blocked; a forward op queued behind it.
      set_issue(4'b1101, 12'h004, 1'b1, 1'b0, 2'd2, 7'd1, 7'd1);
      expect_wb(4'b1101, 32'h8000_0000, 12'h004, 7'd1, 7'd1);
      bus.wb_ready = 1'b0;
      cyc();
      bus.forward_data_by_bank[2] = 32'h8000_0000;
      set_issue(4'b0000, 12'h001, 1'b1, 1'b0, 2'd0, 7'd2, 7'd2);
      expect_wb(4'b0000, 32'h0000_1234, 12'h001, 7'd2, 7'd2);
      cyc();
      bus.issue_valid = 1'b0;
      bus.forward_data_by_bank[2] = 32'hDEAD_BEEF;
      bus.forward_data_by_bank[0] = 32'h0000_1234;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("sra_held_data", bus.wb_data, 32'hF800_0000);
         check("sra_issue_ready", 32'(bus.issue_ready), 32'd0);
         cyc();
         bus.forward_data_by_bank[0] = 32'hDEAD_BEEF;
      end
      bus.wb_ready = 1'b1;
      repeat (3) cyc();

      // SLTU from bank 1, ack only in the fourth OC cycle; other banks ack junk.
      set_issue(4'b0011, 12'h001, 1'b0, 1'b0, 2'd1, 7'd3, 7'd3);
      expect_wb(4'b0011, 32'h0, 12'h001, 7'd3, 7'd3);
      cyc();
      bus.issue_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.reg_read_ack_by_bank = (k == 3) ? 4'b0010 : 4'b0101;
         bus.reg_read_data_by_bank[1] = (k == 3) ? 32'h0 : 32'hFFFF_FFFF;
         @(negedge clk);
         check("stall_issue_ready", 32'(bus.issue_ready), (k == 3) ? 32'd1 : 32'd0);
         cyc();
      end
      idle_inputs();
      set_issue(4'b0010, 12'h000, 1'b0, 1'b0, 2'd1, 7'd6, 7'd7);
      expect_wb(4'b0010, 32'hFFFF_FFFF, 12'h000, 7'd6, 7'd7);
      cyc();
      idle_inputs();
      bus.reg_read_ack_by_bank     = 4'b0010;
      bus.reg_read_data_by_bank[1] = 32'hFFFF_FFFF;
      cyc();
      idle_inputs();
      repeat (2) cyc();

      // ORI waiting on bank 3 ignores bank 0 acks.
      set_issue(4'b0110, 12'h00F, 1'b0, 1'b0, 2'd3, 7'd4, 7'd4);
      expect_wb(4'b0110, 32'h0000_0010, 12'h00F, 7'd4, 7'd4);
      cyc();
      bus.issue_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.reg_read_ack_by_bank     = (k == 2) ? 4'b1000 : 4'b0001;
         bus.reg_read_data_by_bank[0] = 32'hFFFF_FFFF;
         bus.reg_read_data_by_bank[3] = (k == 2) ? 32'h0000_0010 : 32'h0000_0F00;
         @(negedge clk);
         if (k < 2) check("bank_mismatch_stall", 32'(bus.issue_ready), 32'd0);
         cyc();
      end
      idle_inputs();
      repeat (3) cyc();

      // Four back-to-back zero-operand ADDIs: full throughput.
      for (int j = 0; j < 8; j++) begin
         if (j < 4) begin
            set_issue(4'b0000, 12'(j + 1), 1'b0, 1'b1, 2'd0, 7'(10 + j), 7'(20 + j));
            expect_wb(4'b0000, 32'h0, 12'(j + 1), 7'(10 + j), 7'(20 + j));
         end else begin
            bus.issue_valid = 1'b0;
         end
         @(negedge clk);
         if (j < 4) check("b2b_issue_ready", 32'(bus.issue_ready), 32'd1);
         vbits[j] = bus.wb_valid;
         cyc();
      end
      check("b2b_wb_pattern", 32'(vbits), 32'h0000_003C);

      // Reset with OC and WB both occupied discards everything.
      bus.wb_ready = 1'b0;
      set_issue(4'b0000, 12'h007, 1'b0, 1'b1, 2'd0, 7'd1, 7'd1);
      cyc();
      set_issue(4'b0000, 12'h001, 1'b0, 1'b0, 2'd2, 7'd2, 7'd2);
      cyc();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_wb_valid", 32'(bus.wb_valid), 32'd1);
      check("pre_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_mid_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("rst_mid_wb_data", bus.wb_data, 32'd0);
      check("rst_mid_issue_ready", 32'(bus.issue_ready), 32'd1);
      cyc();
      bus.wb_ready                 = 1'b1;
      bus.reg_read_ack_by_bank     = 4'b0100;
      bus.reg_read_data_by_bank[2] = 32'h0000_0055;
      repeat (4) cyc();
      idle_inputs();
      cyc();

      // Randomized traffic, then drain.
      for (int k = 0; k < 600; k++) rand_cycle(1'b1);
      for (int k = 0; k < 300 && (exp_q.size() != 0 || occ); k++) rand_cycle(1'b0);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      idle_inputs();
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
